// File: rtl/main_result_streamer.sv
// Readout end of the solver core's wide result bus: captures the parallel result
// vector on start and streams it one word per valid/ready transfer with a running sum.
module main_result_streamer #(
    parameter int DATA_LEN = 18,
    parameter int WORDS    = 384,
    parameter int IDX_W    = 9,
    parameter int SUM_W    = 27
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [WORDS*DATA_LEN-1:0] data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_LEN-1:0]       out_data,
    output logic [IDX_W-1:0]          out_index,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic [SUM_W-1:0]          sum
);

    localparam int VEC_W = WORDS * DATA_LEN;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [SUM_W-1:0]   sum_q, sum_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            index_q  <= '0;
            sum_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            index_q  <= index_d;
            sum_q    <= sum_d;
        end
    end

    // The shadow register shifts right on every accepted word, so the current
    // word is always its low slice and drains to zero once the stream ends.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        index_d  = index_q;
        sum_d    = sum_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d = data_in;
                    index_d  = '0;
                    sum_d    = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    sum_d    = sum_q + SUM_W'(shadow_q[DATA_LEN-1:0]);
                    shadow_d = shadow_q >> DATA_LEN;
                    if (index_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid = (state_q == STREAM);
    assign out_data  = shadow_q[DATA_LEN-1:0];
    assign out_index = index_q;
    assign out_last  = out_valid && (index_q == LAST_IDX);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;

endmodule
